// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, receiver state encoding and default counter width
package vga_pkg;

    localparam int CW_DEF   = 12;

    // 1024x768 @ 60 Hz on a 65 MHz pixel clock
    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} rx_state_e;

endpackage

// File: rtl/vga_rx_if.sv
// vga_rx_if: VGA video bus (sync, display enable, colour) between generator and receiver
interface vga_rx_if;

    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;

    modport master (output vga_hs, vga_vs, vga_blank, vga_r, vga_g, vga_b);
    modport slave  (input  vga_hs, vga_vs, vga_blank, vga_r, vga_g, vga_b);

endinterface

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers a sync input in asserted-high form and flags its leading edge
module vga_sync_edge #(
    parameter bit POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_i,
    output logic edge_o
);

    logic s1_q, s2_q;

    // stage 1 holds the normalised sync, stage 2 the previous sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= sync_i ~^ POL;
            s2_q <= s1_q;
        end
    end

    assign edge_o = s1_q && !s2_q;

endmodule

// File: rtl/vga_rx.sv
// vga_rx: VGA timing decoder and frame checker; define VGA_RX_CHKSUM_EN for the per-frame pixel checksum
module vga_rx
    import vga_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int TIMEOUT = 4095
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_rx_if.slave       vga,
    output logic          pix_de,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [23:0]   pix_rgb,
    output logic          frame_start,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] v_active,
    output logic          locked,
    output logic          err,
    output logic [31:0]   frame_sum
);

    localparam logic [CW-1:0] SAT = '1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT - 1);

    function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
        return (v == SAT) ? v : v + CW'(1);
    endfunction

    function automatic logic ok(input logic [CW-1:0] v);
        return (v != '0) && (v != SAT);
    endfunction

    logic            hs_e, vs_e, de1_q, line_de_q, line_de_d, ln_de, valid, tmo;
    logic [23:0]     rgb1_q, pix_rgb_q;
    logic [CW-1:0]   hc_q, hc_d, xc_q, xc_d, xc_cur, yc_q, yc_cur, vc_q, va_q;
    logic [CW-1:0]   ht_q, ha_q, ht_new, ha_new, vt_new, va_new, pix_x_q, pix_y_q;
    logic [4*CW-1:0] meas_new, meas_q;
    logic            pix_de_q, fs_q, locked_q, err_q;
    rx_state_e       state_q;

    vga_sync_edge #(.POL(HS_POL)) u_hs (.clk(clk), .rst_n(rst_n), .sync_i(vga.vga_hs), .edge_o(hs_e));
    vga_sync_edge #(.POL(VS_POL)) u_vs (.clk(clk), .rst_n(rst_n), .sync_i(vga.vga_vs), .edge_o(vs_e));

    // next counter values; a simultaneous HS/VS edge closes the line before the frame
    always_comb begin
        ln_de     = hs_e && line_de_q;
        xc_cur    = hs_e ? '0 : xc_q;
        xc_d      = de1_q ? inc(xc_cur) : xc_cur;
        hc_d      = hs_e ? '0 : inc(hc_q);
        ht_new    = hs_e ? inc(hc_q) : ht_q;
        ha_new    = ln_de ? xc_q : ha_q;
        line_de_d = (line_de_q && !hs_e) || de1_q;
        yc_cur    = vs_e ? '0 : (ln_de ? inc(yc_q) : yc_q);
        va_new    = ln_de ? inc(va_q) : va_q;
        vt_new    = hs_e ? inc(vc_q) : vc_q;
        meas_new  = {ht_new, ha_new, vt_new, va_new};
        valid     = ok(ht_new) && ok(ha_new) && ok(vt_new) && ok(va_new);
        tmo       = !hs_e && (hc_q == TMO);
    end

    // input stage, line/frame counters and the registered pixel path
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de1_q     <= 1'b0;
            rgb1_q    <= '0;
            hc_q      <= '0;
            xc_q      <= '0;
            yc_q      <= '0;
            vc_q      <= '0;
            va_q      <= '0;
            ht_q      <= '0;
            ha_q      <= '0;
            line_de_q <= 1'b0;
            pix_de_q  <= 1'b0;
            pix_rgb_q <= '0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
        end else begin
            de1_q     <= vga.vga_blank;
            rgb1_q    <= {vga.vga_r, vga.vga_g, vga.vga_b};
            hc_q      <= hc_d;
            xc_q      <= xc_d;
            yc_q      <= yc_cur;
            vc_q      <= vs_e ? '0 : vt_new;
            va_q      <= vs_e ? '0 : va_new;
            ht_q      <= ht_new;
            ha_q      <= ha_new;
            line_de_q <= line_de_d;
            pix_de_q  <= de1_q;
            pix_rgb_q <= rgb1_q;
            if (de1_q) begin
                pix_x_q <= xc_cur;
                pix_y_q <= yc_cur;
            end
        end
    end

    // lock state machine with registered measurement, lock and error outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SEARCH;
            meas_q   <= '0;
            fs_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fs_q  <= vs_e;
            err_q <= 1'b0;
            if (tmo) begin
                state_q  <= SEARCH;
                locked_q <= 1'b0;
                err_q    <= locked_q;
            end else if (vs_e) begin
                case (state_q)
                    SEARCH: state_q <= MEASURE;
                    MEASURE: begin
                        meas_q <= meas_new;
                        if (valid) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                    default: if (meas_new != meas_q) begin
                        meas_q   <= meas_new;
                        err_q    <= 1'b1;
                        locked_q <= 1'b0;
                        state_q  <= MEASURE;
                    end
                endcase
            end
        end
    end

`ifdef VGA_RX_CHKSUM_EN
    logic [31:0] acc_q, sum_q;

    // accumulate DE pixels per frame and publish the completed sum at the VS edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= (vs_e ? 32'd0 : acc_q) + (de1_q ? {8'd0, rgb1_q} : 32'd0);
            if (vs_e) sum_q <= acc_q;
        end
    end

    assign frame_sum = sum_q;
`else
    assign frame_sum = '0;
`endif

    assign pix_de      = pix_de_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_rgb     = pix_rgb_q;
    assign frame_start = fs_q;
    assign locked      = locked_q;
    assign err         = err_q;
    assign {h_total, h_active, v_total, v_active} = meas_q;

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: directed frame sequences for vga_rx covering lock, coordinates, mismatch, timeout, reset and checksum
module tb_vga_rx;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_rx_if vif();

    logic        pix_de, frame_start, locked, err;
    logic [11:0] pix_x, pix_y, h_total, h_active, v_total, v_active;
    logic [23:0] pix_rgb;
    logic [31:0] frame_sum;

    vga_rx dut (
        .clk(clk), .rst_n(rst_n), .vga(vif),
        .pix_de(pix_de), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .h_total(h_total), .h_active(h_active),
        .v_total(v_total), .v_active(v_active), .locked(locked), .err(err),
        .frame_sum(frame_sum)
    );

`ifdef VGA_RX_CHKSUM_EN
    localparam bit          CHK_EN  = 1'b1;
    localparam logic [31:0] CHK_EXP = 32'h0048_90D8;
`else
    localparam bit          CHK_EN  = 1'b0;
    localparam logic [31:0] CHK_EXP = 32'h0;
`endif

    int nvec = 0, nfail = 0;
    int de_obs, since, o_since, p_since;
    bit last_hs, last_vs, yok, quiet, cpx, cur_lock, xl, xe;
    bit p_de, p_vse, p_yok;
    int p_x, p_y, xm0, xm1, xm2, xm3;
    logic [23:0] p_rgb;
    logic [31:0] acc, snap, p_sum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " pix_de"}, pix_de, 0);
        chk({tag, " pix_x"}, pix_x, 0);
        chk({tag, " pix_y"}, pix_y, 0);
        chk({tag, " pix_rgb"}, pix_rgb, 0);
        chk({tag, " frame_start"}, frame_start, 0);
        chk({tag, " meas"}, {h_total, h_active, v_total, v_active}, 0);
        chk({tag, " locked"}, locked, 0);
        chk({tag, " err"}, err, 0);
        chk({tag, " frame_sum"}, frame_sum, 0);
    endtask

    task automatic drive(input logic hs, vs, de, input logic [23:0] rgb);
        vif.vga_hs = hs;
        vif.vga_vs = vs;
        vif.vga_blank = de;
        {vif.vga_r, vif.vga_g, vif.vga_b} = rgb;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 24'h0);
        last_hs = 1'b1;
        last_vs = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_zero("reset");
        p_de = 0; p_vse = 0; p_yok = 0; yok = 0;
        since = 0; acc = 0; cur_lock = 0;
    endtask

    // one pixel clock; outputs observed here belong to the previous call's inputs
    task automatic step(input logic hs, vs, de, input logic [23:0] rgb, input int ex, ey);
        bit hse, vse;
        hse = last_hs && !hs;
        vse = last_vs && !vs;
        last_hs = hs;
        last_vs = vs;
        since = hse ? 0 : since + 1;
        if (vse) begin
            snap = acc;
            acc = 0;
            yok = 1;
        end
        if (de) acc = acc + {8'd0, rgb};
        drive(hs, vs, de, rgb);
        @(posedge clk);
        #1;
        chk("pix_de", pix_de, p_de);
        if (p_de) begin
            chk("pix_x", pix_x, p_x);
            if (p_yok) chk("pix_y", pix_y, p_y);
            chk("pix_rgb", pix_rgb, p_rgb);
        end
        if (pix_de) de_obs++;
        if (p_vse) begin
            chk("frame_start", frame_start, 1);
            chk("locked@vs", locked, xl);
            chk("err@vs", err, xe);
            chk("h_total", h_total, xm0);
            chk("h_active", h_active, xm1);
            chk("v_total", v_total, xm2);
            chk("v_active", v_active, xm3);
            chk("frame_sum", frame_sum, p_sum);
            cur_lock = xl;
        end else if (quiet) begin
            chk("frame_start idle", frame_start, 0);
            chk("err idle", err, 0);
            chk("locked hold", locked, cur_lock);
        end
        o_since = p_since;
        p_de = de; p_x = ex; p_y = ey; p_rgb = rgb; p_vse = vse;
        p_since = since; p_yok = yok; p_sum = CHK_EN ? snap : 32'h0;
    endtask

    // 10-line frame: DE on lines 0..5 pixels 0..11, HS low at pixels 14..15, VS low on lines 8..9
    task automatic lines(input int htot, l0, l1);
        for (int l = l0; l <= l1; l++) begin
            for (int p = 0; p < htot; p++) begin
                logic de;
                logic [23:0] c;
                de = (l < 6) && (p < 12);
                c = cpx ? 24'h010203 : {8'(p), 8'(l), 8'(p * 7 + l + 1)};
                step(!(p == 14 || p == 15), !(l == 8 || l == 9), de, de ? c : 24'h0, p, l);
            end
        end
    endtask

    task automatic expect_vs(input bit l, e, input int ht, ha, vt, va);
        xl = l; xe = e; xm0 = ht; xm1 = ha; xm2 = vt; xm3 = va;
    endtask

    task automatic frame(input int htot, input bit l, e, input int ht, ha, vt, va);
        expect_vs(l, e, ht, ha, vt, va);
        de_obs = 0;
        lines(htot, 0, 9);
        chk("de per frame", de_obs, 72);
    endtask

    initial begin
        bit found;
        quiet = 1; cpx = 0; snap = 0; p_since = 0;
        do_reset();
        yok = 1;
        frame(20, 0, 0, 0, 0, 0, 0);
        frame(20, 1, 0, 20, 12, 10, 6);
        frame(20, 1, 0, 20, 12, 10, 6);
        frame(21, 0, 1, 21, 12, 10, 6);
        frame(21, 1, 0, 21, 12, 10, 6);

        quiet = 0;
        found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, 24'h0, 0, 0);
            if (err === 1'b1) begin
                found = 1;
                chk("timeout clocks", o_since, 4095);
                chk("timeout locked", locked, 0);
                chk("timeout state", dut.state_q, SEARCH);
            end
        end
        chk("timeout seen", 32'(found), 1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 24'h0, 0, 0);
            chk("timeout err once", err, 0);
        end
        cur_lock = 0;
        quiet = 1;

        frame(20, 0, 0, 21, 12, 10, 6);
        frame(20, 1, 0, 20, 12, 10, 6);

        lines(20, 0, 3);
        do_reset();
        expect_vs(0, 0, 0, 0, 0, 0);
        lines(20, 4, 9);
        cpx = 1;
        frame(20, 1, 0, 20, 12, 10, 6);
        chk("frame_sum const", frame_sum, CHK_EXP);
        cpx = 0;
        frame(20, 1, 0, 20, 12, 10, 6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
